// File: rtl/game_pkg.sv
// Shared game constants: one-hot state codes, playfield bounds and park position.
// Used by the projectile, the enemy fleet and the VGA renderer.
package game_pkg;
    localparam logic [4:0] ST_INIT   = 5'b00001;
    localparam logic [4:0] ST_READY  = 5'b00010;
    localparam logic [4:0] ST_FLIGHT = 5'b00100;
    localparam logic [4:0] ST_COOL   = 5'b01000;
    localparam logic [4:0] ST_DONE   = 5'b10000;

    localparam logic [9:0] PARK_H_DEF   = 10'd0;
    localparam logic [9:0] PARK_V_DEF   = 10'd0;
    localparam logic [9:0] LAUNCH_V_DEF = 10'd50;
    localparam logic [9:0] TOP_V_DEF    = 10'd515;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/player_projectile_if.sv
// Bundle between the player's projectile, its controls and the enemy fleet.
interface player_projectile_if;
    logic       start;
    logic       fire;
    logic [9:0] player_h;
    logic       collision;
    logic       game_over;
    logic [9:0] projectile_h;
    logic [9:0] projectile_v;
    logic       projectile_active;
    logic [7:0] shots_fired;
    logic [7:0] hits;

    modport master (
        output start, fire, player_h, collision, game_over,
        input  projectile_h, projectile_v, projectile_active, shots_fired, hits
    );
    modport slave (
        input  start, fire, player_h, collision, game_over,
        output projectile_h, projectile_v, projectile_active, shots_fired, hits
    );
endinterface

// File: rtl/tick_divider.sv
// Programmable cycle divider: counts while enabled and pulses o_tc on the
// last cycle of each period of i_div cycles.
module tick_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_div,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == i_div - W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               r_cnt <= '0;
        else if (i_clr || o_tc)  r_cnt <= '0;
        else if (i_en)           r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/player_projectile.sv
// Player's single shot: launch on fire edge, climb on a divided tick, retire on
// hit or top of playfield, then cool down before the next shot is allowed.
module player_projectile
    import game_pkg::*;
#(
    parameter logic [15:0] STEP_DIV = 16'd50000,
    parameter logic [9:0]  STEP_PX  = 10'd10,
    parameter logic [9:0]  LAUNCH_V = LAUNCH_V_DEF,
    parameter logic [9:0]  TOP_V    = TOP_V_DEF,
    parameter logic [15:0] COOLDOWN = 16'd100,
    parameter logic [9:0]  PARK_H   = PARK_H_DEF,
    parameter logic [9:0]  PARK_V   = PARK_V_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    player_projectile_if.slave   bus
);
    logic [4:0]  r_state;
    logic        r_fire_prev;
    logic [9:0]  r_h, r_v;
    logic        r_active;
    logic [7:0]  r_shots, r_hits;
    logic [15:0] r_cd;

    logic        w_fire_edge, w_tc, w_miss, w_in_flight;
    logic [10:0] w_next_v;

    assign w_fire_edge = bus.fire & ~r_fire_prev;
    assign w_in_flight = (r_state == ST_FLIGHT);
    // 11-bit sum so a step near the 10-bit ceiling cannot wrap into range
    assign w_next_v    = {1'b0, r_v} + {1'b0, STEP_PX};
    assign w_miss      = w_next_v > {1'b0, TOP_V};

    tick_divider #(.W(16)) u_step (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_in_flight),
        .i_clr (!w_in_flight),
        .i_div (STEP_DIV),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_fire_prev <= 1'b0;
            r_h         <= PARK_H;
            r_v         <= PARK_V;
            r_active    <= 1'b0;
            r_shots     <= 8'd0;
            r_hits      <= 8'd0;
            r_cd        <= 16'd0;
        end else begin
            r_fire_prev <= bus.fire;
            case (r_state)
                ST_INIT: begin
                    r_h      <= PARK_H;
                    r_v      <= PARK_V;
                    r_active <= 1'b0;
                    r_cd     <= 16'd0;
                    if (bus.start) r_state <= ST_READY;
                end
                ST_READY: begin
                    if (bus.game_over) begin
                        r_state <= ST_DONE;
                    end else if (w_fire_edge) begin
                        r_state  <= ST_FLIGHT;
                        r_h      <= bus.player_h;
                        r_v      <= LAUNCH_V;
                        r_active <= 1'b1;
                        r_shots  <= sat_inc8(r_shots);
                    end
                end
                ST_FLIGHT: begin
                    if (bus.collision) r_hits <= sat_inc8(r_hits);
                    if (bus.game_over) begin
                        r_state  <= ST_DONE;
                        r_h      <= PARK_H;
                        r_v      <= PARK_V;
                        r_active <= 1'b0;
                    end else if (bus.collision || (w_tc && w_miss)) begin
                        r_state  <= ST_COOL;
                        r_h      <= PARK_H;
                        r_v      <= PARK_V;
                        r_active <= 1'b0;
                        r_cd     <= COOLDOWN - 16'd1;
                    end else if (w_tc) begin
                        r_v <= w_next_v[9:0];
                    end
                end
                ST_COOL: begin
                    if (bus.game_over)    r_state <= ST_DONE;
                    else if (r_cd == 0)   r_state <= ST_READY;
                    else                  r_cd    <= r_cd - 16'd1;
                end
                ST_DONE: ;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bus.projectile_h      = r_h;
    assign bus.projectile_v      = r_v;
    assign bus.projectile_active = r_active;
    assign bus.shots_fired       = r_shots;
    assign bus.hits              = r_hits;
endmodule

// File: tb/tb_player_projectile.sv
// Randomised + directed bench; a flight-time based reference model predicts outputs.
module tb_player_projectile;
    localparam int DIV = 4, PX = 10, LV = 50, TOP = 100, CD = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    player_projectile_if bus ();

    player_projectile #(
        .STEP_DIV(16'(DIV)), .STEP_PX(10'(PX)), .LAUNCH_V(10'(LV)), .TOP_V(10'(TOP)),
        .COOLDOWN(16'(CD)), .PARK_H(10'd0), .PARK_V(10'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    // Model: the shot's height follows from how many cycles it has been flying.
    typedef enum int {M_INIT, M_READY, M_FLY, M_COOL, M_DONE} mode_t;
    mode_t m_mode;
    int    m_fly, m_cd, m_shots, m_hits, m_h;
    bit    m_prev;

    function automatic int exp_v();
        return (m_mode == M_FLY) ? LV + PX * (m_fly / DIV) : 0;
    endfunction

    task automatic model_reset();
        m_mode = M_INIT; m_fly = 0; m_cd = 0; m_shots = 0; m_hits = 0; m_h = 0; m_prev = 0;
    endtask

    task automatic model_step();
        bit edge_s;
        int nxt;
        edge_s = bus.fire && !m_prev;
        m_prev = bus.fire;
        case (m_mode)
            M_INIT:  if (bus.start) m_mode = M_READY;
            M_READY: begin
                if (bus.game_over) m_mode = M_DONE;
                else if (edge_s) begin
                    m_mode = M_FLY; m_fly = 0; m_h = int'(bus.player_h);
                    if (m_shots < 255) m_shots++;
                end
            end
            M_FLY: begin
                if (bus.collision && m_hits < 255) m_hits++;
                nxt = m_fly + 1;
                if (bus.game_over) m_mode = M_DONE;
                else if (bus.collision) begin m_mode = M_COOL; m_cd = CD; end
                else if (nxt % DIV == 0 && LV + PX * (nxt / DIV) > TOP) begin m_mode = M_COOL; m_cd = CD; end
                else m_fly = nxt;
            end
            M_COOL: begin
                if (bus.game_over) m_mode = M_DONE;
                else begin
                    m_cd--;
                    if (m_cd == 0) m_mode = M_READY;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_outs();
        chk("proj_h", 32'(bus.projectile_h), (m_mode == M_FLY) ? m_h : 0);
        chk("proj_v", 32'(bus.projectile_v), exp_v());
        chk("active", 32'(bus.projectile_active), (m_mode == M_FLY) ? 1 : 0);
        chk("shots", 32'(bus.shots_fired), m_shots);
        chk("hits", 32'(bus.hits), m_hits);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_outs();
    endtask

    task automatic wait_mode(input mode_t m);
        int n = 0;
        while (m_mode != m && n < 300) begin cyc(); n++; end
        if (m_mode != m) chk("wait_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.fire = 0; bus.player_h = 0; bus.collision = 0; bus.game_over = 0;
        model_reset();
        #12;
        chk("rst_h", 32'(bus.projectile_h), 0);
        chk("rst_v", 32'(bus.projectile_v), 0);
        chk("rst_active", 32'(bus.projectile_active), 0);
        chk("rst_shots", 32'(bus.shots_fired), 0);
        chk("rst_hits", 32'(bus.hits), 0);
        @(negedge clk) reset = 1'b0;
        bus.game_over = 1; cyc(); bus.game_over = 0;   // no effect in INIT
        bus.start = 1; cyc();

        // first launch, then let it miss and cool down
        bus.player_h = 10'd200; bus.fire = 1; cyc(); bus.fire = 0;
        chk("launch_h", 32'(bus.projectile_h), 200);
        chk("launch_v", 32'(bus.projectile_v), 50);
        chk("launch_act", 32'(bus.projectile_active), 1);
        chk("launch_shots", 32'(bus.shots_fired), 1);
        repeat (4) cyc();
        chk("step1_v", 32'(bus.projectile_v), 60);
        wait_mode(M_COOL);
        chk("miss_park_v", 32'(bus.projectile_v), 0);
        wait_mode(M_READY);

        // hit at v=70
        bus.fire = 1; cyc(); bus.fire = 0;
        begin int n = 0; while (exp_v() != 70 && n < 100) begin cyc(); n++; end end
        chk("at70", 32'(bus.projectile_v), 70);
        bus.collision = 1; cyc(); bus.collision = 0;
        chk("hit_park_v", 32'(bus.projectile_v), 0);
        chk("hit_count", 32'(bus.hits), 1);
        wait_mode(M_READY);

        // hit coinciding with a terminal count
        bus.fire = 1; cyc(); bus.fire = 0;
        begin int n = 0; while (!(m_mode == M_FLY && m_fly == 2*DIV - 1) && n < 100) begin cyc(); n++; end end
        bus.collision = 1; cyc(); bus.collision = 0;
        chk("tc_hit_v", 32'(bus.projectile_v), 0);
        chk("tc_hit_count", 32'(bus.hits), 2);
        wait_mode(M_READY);

        // held fire: a single launch only
        bus.fire = 1; repeat (40) cyc();
        chk("held_shots", 32'(bus.shots_fired), 4);
        bus.fire = 0; cyc(); wait_mode(M_READY);
        bus.fire = 1; cyc(); bus.fire = 0;
        chk("repress_shots", 32'(bus.shots_fired), 5);
        bus.collision = 1; cyc(); bus.collision = 0;
        bus.fire = 1; cyc(); bus.fire = 0;               // press during cooldown
        wait_mode(M_READY); repeat (3) cyc();
        chk("cool_drop_shots", 32'(bus.shots_fired), 5);

        // random traffic
        repeat (1500) begin
            bus.fire      = ($urandom_range(0, 3) == 0);
            bus.collision = ($urandom_range(0, 15) == 0);
            bus.player_h  = 10'($urandom_range(0, 639));
            cyc();
        end
        bus.fire = 0; bus.collision = 0;

        // saturation of the launch counter
        repeat (260) begin
            wait_mode(M_READY);
            bus.player_h = 10'($urandom_range(0, 639));
            bus.fire = 1; cyc(); bus.fire = 0; cyc();
            if ($urandom_range(0, 1) == 1) begin bus.collision = 1; cyc(); bus.collision = 0; end
        end
        chk("shots_sat", 32'(bus.shots_fired), 255);

        // game over mid-flight with a simultaneous hit
        wait_mode(M_READY);
        bus.fire = 1; cyc(); bus.fire = 0; repeat (5) cyc();
        bus.game_over = 1; bus.collision = 1; cyc(); bus.collision = 0; bus.game_over = 0;
        chk("go_active", 32'(bus.projectile_active), 0);
        repeat (10) begin
            bus.start = ~bus.start; bus.fire = 1; cyc(); bus.fire = 0; cyc();
        end
        chk("done_shots", 32'(bus.shots_fired), 255);
        chk("done_active", 32'(bus.projectile_active), 0);

        // reset in the middle of a flight
        reset = 1'b1; model_reset(); #1;
        @(negedge clk) reset = 1'b0;
        bus.start = 1; cyc();
        bus.player_h = 10'd321; bus.fire = 1; cyc(); bus.fire = 0;
        bus.collision = 1; cyc(); bus.collision = 0; wait_mode(M_READY);
        bus.fire = 1; cyc(); bus.fire = 0; repeat (6) cyc();
        chk("pre_rst_act", 32'(bus.projectile_active), 1);
        #2 reset = 1'b1; model_reset();
        #1;
        chk("mid_rst_h", 32'(bus.projectile_h), 0);
        chk("mid_rst_v", 32'(bus.projectile_v), 0);
        chk("mid_rst_act", 32'(bus.projectile_active), 0);
        chk("mid_rst_shots", 32'(bus.shots_fired), 0);
        chk("mid_rst_hits", 32'(bus.hits), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
